// File: rtl/counter_sequencer_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and the
// widths of the external parallel-load counter and the period counter.
package counter_sequencer_pkg;

  localparam int unsigned CTR_W  = 4;
  localparam int unsigned PCNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE,
    S_CLEAR
  } state_t;

endpackage

// File: rtl/increment_prescaler.sv
// Prescaler for the counter increment strobe.
// Counts 0..PRESCALE-1 while not held; tick is high while the count sits at
// PRESCALE-1.
//   clk   : system clock
//   reset : synchronous active-high reset, zeroes the count
//   clear : synchronous clear, zeroes the count
//   hold  : freeze the count at its current value
//   tick  : count equals PRESCALE-1
module increment_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);

  localparam logic [3:0] LAST = 4'(PRESCALE - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 4'd1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer driving an external 4-bit parallel-load counter through
// clear/load/increment strobes. Runs one-shot or auto-reload count periods
// from a latched reload value, with pause, abort and a period counter.
//   clk, reset          : system clock, synchronous active-high reset
//   start, stop, pause  : run control (start sampled in IDLE only)
//   mode_periodic       : 0 one-shot, 1 auto-reload (latched on start)
//   reload_value        : counter start value (latched on start)
//   ctr_clear/load/increment, ctr_I : counter control strobes and load data
//   ctr_A, ctr_carry    : counter value and carry
//   busy, expire, done  : status; expire/done are one-cycle pulses
//   period_count        : expire pulses since the last accepted start
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              mode_periodic,
  input  logic [CTR_W-1:0]  reload_value,
  output logic              ctr_clear,
  output logic              ctr_load,
  output logic              ctr_increment,
  output logic [CTR_W-1:0]  ctr_I,
  input  logic [CTR_W-1:0]  ctr_A,
  input  logic              ctr_carry,
  output logic              busy,
  output logic              expire,
  output logic              done,
  output logic [PCNT_W-1:0] period_count
);

  state_t              state;
  logic [CTR_W-1:0]    reload_q;
  logic                mode_q;
  logic                expire_q;
  logic [PCNT_W-1:0]   pcount_q;
  logic                tick;
  logic                run_tick;
  logic                terminal;

  increment_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state == S_LOAD || state == S_IDLE),
    .hold  (state != S_RUN),
    .tick  (tick)
  );

  assign run_tick = (state == S_RUN) && tick;
  // Carry is cross-checked against the counter value so a stray carry
  // cannot end a period early.
  assign terminal = run_tick && ctr_carry && (ctr_A == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      reload_q <= '0;
      mode_q   <= 1'b0;
      expire_q <= 1'b0;
      pcount_q <= '0;
    end else begin
      expire_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !stop) begin
            reload_q <= reload_value;
            mode_q   <= mode_periodic;
            pcount_q <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: state <= stop ? S_CLEAR : S_RUN;
        S_RUN: begin
          // stop beats terminal beats pause; a pause coincident with the
          // terminal event is honoured in the next RUN cycle.
          if (stop) begin
            state <= S_CLEAR;
          end else if (terminal) begin
            expire_q <= 1'b1;
            pcount_q <= pcount_q + PCNT_W'(1);
            state    <= mode_q ? S_LOAD : S_DONE;
          end else if (pause) begin
            state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (stop) begin
            state <= S_CLEAR;
          end else if (!pause) begin
            state <= S_RUN;
          end
        end
        S_DONE:  state <= stop ? S_CLEAR : S_IDLE;
        S_CLEAR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Decoded outputs are forced inactive while reset is high so the counter
  // never sees a stale load/increment alongside the reset clear.
  always_comb begin
    ctr_clear     = reset || (state == S_CLEAR);
    ctr_load      = 1'b0;
    ctr_increment = 1'b0;
    ctr_I         = '0;
    busy          = 1'b0;
    expire        = 1'b0;
    done          = 1'b0;
    if (!reset) begin
      ctr_load      = (state == S_LOAD);
      ctr_increment = run_tick;
      ctr_I         = (state == S_LOAD) ? reload_q : '0;
      busy          = (state != S_IDLE);
      expire        = expire_q;
      done          = (state == S_DONE);
    end
  end

  assign period_count = pcount_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: two instances (PRESCALE 1 and 3) each with a
// behavioural 4-bit parallel-load counter. Expected expire events are queued
// when a run is started and checked by a monitor as expire pulses appear.
module tb_counter_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             stop;
  logic             pause;
  logic             mode_periodic;
  logic [3:0]       reload_value;
  logic [1:0]       start;
  logic [1:0]       ctr_clear, ctr_load, ctr_increment, ctr_carry;
  logic [1:0]       busy, expire, done;
  logic [1:0][3:0]  ctr_I, ctr_A;
  logic [1:0][7:0]  period_count;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [7:0] pc;
    logic       done;
  } exp_t;

  exp_t q [2][$];

  counter_sequencer #(.PRESCALE(1)) dut_p1 (
    .clk           (clk),
    .reset         (reset),
    .start         (start[0]),
    .stop          (stop),
    .pause         (pause),
    .mode_periodic (mode_periodic),
    .reload_value  (reload_value),
    .ctr_clear     (ctr_clear[0]),
    .ctr_load      (ctr_load[0]),
    .ctr_increment (ctr_increment[0]),
    .ctr_I         (ctr_I[0]),
    .ctr_A         (ctr_A[0]),
    .ctr_carry     (ctr_carry[0]),
    .busy          (busy[0]),
    .expire        (expire[0]),
    .done          (done[0]),
    .period_count  (period_count[0])
  );

  counter_sequencer #(.PRESCALE(3)) dut_p3 (
    .clk           (clk),
    .reset         (reset),
    .start         (start[1]),
    .stop          (stop),
    .pause         (pause),
    .mode_periodic (mode_periodic),
    .reload_value  (reload_value),
    .ctr_clear     (ctr_clear[1]),
    .ctr_load      (ctr_load[1]),
    .ctr_increment (ctr_increment[1]),
    .ctr_I         (ctr_I[1]),
    .ctr_A         (ctr_A[1]),
    .ctr_carry     (ctr_carry[1]),
    .busy          (busy[1]),
    .expire        (expire[1]),
    .done          (done[1]),
    .period_count  (period_count[1])
  );

  // External parallel-load counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (ctr_clear[i])          ctr_A[i] <= 4'd0;
      else if (ctr_load[i])      ctr_A[i] <= ctr_I[i];
      else if (ctr_increment[i]) ctr_A[i] <= ctr_A[i] + 4'd1;
    end
  end

  always_comb begin
    ctr_carry = '0;
    for (int i = 0; i < 2; i++)
      ctr_carry[i] = ctr_increment[i] && (ctr_A[i] == 4'hF);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int exp_cyc(input int c0, input int r, input int p);
    return c0 + 2 + (16 - r) * p;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("strobe_onehot%0d", i),
          32'($countones({ctr_clear[i], ctr_load[i], ctr_increment[i]}) <= 1), 32'd1);
      if (q[i].size() > 0 && q[i][0].cyc < cyc) begin
        e = q[i].pop_front();
        chk($sformatf("expire_missing%0d", i), 32'(cyc), 32'(e.cyc));
      end
      if (expire[i]) begin
        if (q[i].size() == 0) begin
          chk($sformatf("expire_unexpected%0d", i), 32'(expire[i]), 32'd0);
        end else begin
          e = q[i].pop_front();
          chk($sformatf("expire_cycle%0d", i), 32'(cyc), 32'(e.cyc));
          chk($sformatf("period_count%0d", i), 32'(period_count[i]), 32'(e.pc));
          chk($sformatf("done_with_expire%0d", i), 32'(done[i]), 32'(e.done));
        end
      end else if (done[i]) begin
        chk($sformatf("done_unexpected%0d", i), 32'(done[i]), 32'd0);
      end
    end
  end

  initial begin
    int c0;
    reset = 1'b1; start = '0; stop = 1'b0; pause = 1'b0;
    mode_periodic = 1'b0; reload_value = 4'd0;

    // Reset state
    step(2);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ctr_clear", 32'(ctr_clear[i]), 32'd1);
      chk("rst_ctr_load", 32'(ctr_load[i]), 32'd0);
      chk("rst_ctr_inc", 32'(ctr_increment[i]), 32'd0);
      chk("rst_ctr_I", 32'(ctr_I[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_pcount", 32'(period_count[i]), 32'd0);
    end
    reset = 1'b0;
    step(1);
    chk("idle_busy", 32'(busy[0]), 32'd0);

    // One-shot, PRESCALE=1, reload 13
    reload_value = 4'd13; mode_periodic = 1'b0; start[0] = 1'b1; c0 = cyc;
    q[0].push_back('{exp_cyc(c0, 13, 1), 8'd1, 1'b1});
    step(1); start[0] = 1'b0;
    chk("t1_load", 32'(ctr_load[0]), 32'd1);
    chk("t1_ctr_I", 32'(ctr_I[0]), 32'd13);
    chk("t1_busy", 32'(busy[0]), 32'd1);
    step(1);
    chk("t1_A13", 32'(ctr_A[0]), 32'd13);
    chk("t1_inc", 32'(ctr_increment[0]), 32'd1);
    step(1);
    chk("t1_A14", 32'(ctr_A[0]), 32'd14);
    step(1);
    chk("t1_A15", 32'(ctr_A[0]), 32'd15);
    chk("t1_carry", 32'(ctr_carry[0]), 32'd1);
    step(1);
    chk("t1_done_busy", 32'(busy[0]), 32'd1);
    chk("t1_A0", 32'(ctr_A[0]), 32'd0);
    step(1);
    chk("t1_idle", 32'(busy[0]), 32'd0);

    // Periodic, PRESCALE=3, reload 14, three periods then stop
    reload_value = 4'd14; mode_periodic = 1'b1; start[1] = 1'b1; c0 = cyc;
    for (int k = 0; k < 3; k++)
      q[1].push_back('{exp_cyc(c0, 14, 3) + 7 * k, 8'(k + 1), 1'b0});
    step(1); start[1] = 1'b0;
    step(22);
    stop = 1'b1;
    step(1); stop = 1'b0;
    chk("t2_clear", 32'(ctr_clear[1]), 32'd1);
    step(1);
    chk("t2_A0", 32'(ctr_A[1]), 32'd0);
    chk("t2_idle", 32'(busy[1]), 32'd0);
    chk("t2_pcount", 32'(period_count[1]), 32'd3);

    // Pause for 4 cycles mid-run delays expire by 4
    reload_value = 4'd14; mode_periodic = 1'b0; start[1] = 1'b1; c0 = cyc;
    q[1].push_back('{exp_cyc(c0, 14, 3) + 4, 8'd1, 1'b1});
    step(1); start[1] = 1'b0;
    step(2); pause = 1'b1;
    step(1);
    chk("t3_A_held_a", 32'(ctr_A[1]), 32'd14);
    step(3); pause = 1'b0;
    chk("t3_A_held_b", 32'(ctr_A[1]), 32'd14);
    chk("t3_no_inc", 32'(ctr_increment[1]), 32'd0);
    chk("t3_busy", 32'(busy[1]), 32'd1);
    step(6);
    chk("t3_idle", 32'(busy[1]), 32'd0);

    // Stop at ctr_A = 9
    reload_value = 4'd5; mode_periodic = 1'b0; start[0] = 1'b1;
    step(1); start[0] = 1'b0;
    step(5);
    chk("t4_A9", 32'(ctr_A[0]), 32'd9);
    stop = 1'b1;
    step(1); stop = 1'b0;
    chk("t4_clear", 32'(ctr_clear[0]), 32'd1);
    step(1);
    chk("t4_A0", 32'(ctr_A[0]), 32'd0);
    chk("t4_idle", 32'(busy[0]), 32'd0);
    step(10);

    // Ignored start mid-run, then reset mid-run
    reload_value = 4'd10; mode_periodic = 1'b1; start[1] = 1'b1; c0 = cyc;
    q[1].push_back('{exp_cyc(c0, 10, 3), 8'd1, 1'b0});
    step(1); start[1] = 1'b0;
    step(4);
    reload_value = 4'd3; mode_periodic = 1'b0; start[1] = 1'b1;
    step(1); start[1] = 1'b0;
    step(16);
    reset = 1'b1;
    #1;
    chk("t5_rst_clear", 32'(ctr_clear[1]), 32'd1);
    chk("t5_rst_busy", 32'(busy[1]), 32'd0);
    chk("t5_rst_load", 32'(ctr_load[1]), 32'd0);
    chk("t5_rst_inc", 32'(ctr_increment[1]), 32'd0);
    step(2);
    chk("t5_pcount", 32'(period_count[1]), 32'd0);
    chk("t5_idle", 32'(busy[1]), 32'd0);
    reset = 1'b0;
    step(20);
    chk("t5_still_idle", 32'(busy[1]), 32'd0);

    // period_count wrap: reload 15, PRESCALE=1, 256 periods, stop on terminal
    reload_value = 4'd15; mode_periodic = 1'b1; start[0] = 1'b1; c0 = cyc;
    for (int k = 0; k < 256; k++)
      q[0].push_back('{exp_cyc(c0, 15, 1) + 2 * k, 8'(k + 1), 1'b0});
    step(1); start[0] = 1'b0;
    step(513);
    stop = 1'b1;
    step(1); stop = 1'b0;
    chk("t6_clear", 32'(ctr_clear[0]), 32'd1);
    chk("t6_pcount_wrap", 32'(period_count[0]), 32'd0);
    step(3);
    chk("t6_idle", 32'(busy[0]), 32'd0);

    chk("q0_drained", 32'(q[0].size()), 32'd0);
    chk("q1_drained", 32'(q[1].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
